// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the multi-channel stopwatch.
// State encoding and default counter modulus.
package stopwatch_pkg;

   localparam logic [1:0] STAT_STOP  = 2'd0;
   localparam logic [1:0] STAT_RUN   = 2'd1;
   localparam logic [1:0] STAT_PAUSE = 2'd2;

   // 6000 ticks = 60.00 s at a 100 Hz tick
   localparam int SW_MAX_COUNT = 6000;

   typedef enum logic [1:0] {
      ST_STOP  = STAT_STOP,
      ST_RUN   = STAT_RUN,
      ST_PAUSE = STAT_PAUSE
   } sw_state_t;

   // Next state from the button pulses; 2'b11 falls back to STOP
   function automatic sw_state_t sw_next(
      input sw_state_t cur,
      input logic      ss,
      input logic      pr
   );
      sw_state_t nxt;
      nxt = cur;
      unique case (cur)
         ST_STOP: begin
            if (ss) nxt = ST_RUN;
         end
         ST_RUN: begin
            if (ss)      nxt = ST_STOP;
            else if (pr) nxt = ST_PAUSE;
         end
         ST_PAUSE: begin
            if (ss)      nxt = ST_STOP;
            else if (pr) nxt = ST_RUN;
         end
         default: nxt = ST_STOP;
      endcase
      return nxt;
   endfunction

endpackage

// File: rtl/stopwatch_channel.sv
// One stopwatch channel: run/pause/stop FSM, wrapping counter, lap hold.
// Lap hold is built only when STOPWATCH_LAP_EN is defined.
module stopwatch_channel
   import stopwatch_pkg::*;
#(
   parameter int MAX_COUNT = SW_MAX_COUNT,
   parameter int CNT_W     = $clog2(MAX_COUNT)
) (
   input  logic             clk_100,
   input  logic             rst_n,
   input  logic             tick,
   input  logic             start_stop,
   input  logic             pause_resume,
   input  logic             clear,
   input  logic             lap,
   output logic             running,
   output logic             paused,
   output logic             wrap,
   output logic [CNT_W-1:0] count,
   output logic [CNT_W-1:0] disp_count
);

   localparam logic [CNT_W-1:0] LAST = CNT_W'(MAX_COUNT - 1);

   sw_state_t state;
   sw_state_t state_nxt;
   logic      cnt_en;

   // Next state: clear overrides every button
   always_comb begin
      state_nxt = sw_next(state, start_stop, pause_resume);
      if (clear) state_nxt = ST_STOP;
   end

   // Count only while the registered state is RUN
   assign cnt_en = tick && (state == ST_RUN);

   // FSM register with status flags registered alongside it
   always_ff @(posedge clk_100) begin
      if (!rst_n) begin
         state   <= ST_STOP;
         running <= 1'b0;
         paused  <= 1'b0;
      end else begin
         state   <= state_nxt;
         running <= (state_nxt == ST_RUN);
         paused  <= (state_nxt == ST_PAUSE);
      end
   end

   // Elapsed-tick counter, wrap pulse lands with the return to zero
   always_ff @(posedge clk_100) begin
      if (!rst_n || clear) begin
         count <= '0;
         wrap  <= 1'b0;
      end else begin
         wrap <= 1'b0;
         if (cnt_en) begin
            if (count == LAST) begin
               count <= '0;
               wrap  <= 1'b1;
            end else begin
               count <= count + 1'b1;
            end
         end
      end
   end

`ifdef STOPWATCH_LAP_EN
   logic             hold;
   logic [CNT_W-1:0] lap_q;

   // Lap capture in RUN, release from any state
   always_ff @(posedge clk_100) begin
      if (!rst_n) begin
         hold  <= 1'b0;
         lap_q <= '0;
      end else if (clear) begin
         hold <= 1'b0;
      end else if (lap) begin
         if (hold) begin
            hold <= 1'b0;
         end else if (state == ST_RUN) begin
            lap_q <= count;
            hold  <= 1'b1;
         end
      end
   end

   assign disp_count = hold ? lap_q : count;
`else
   logic lap_unused;

   assign lap_unused = lap;
   assign disp_count = count;
`endif

endmodule

// File: rtl/stopwatch_ctrl_multi.sv
// Multi-channel stopwatch controller: NUM_CH independent channels.
// Optional lap hold per channel via STOPWATCH_LAP_EN.
module stopwatch_ctrl_multi
   import stopwatch_pkg::*;
#(
   parameter int NUM_CH    = 2,
   parameter int MAX_COUNT = SW_MAX_COUNT,
   parameter int CNT_W     = $clog2(MAX_COUNT)
) (
   input  logic                    clk_100,
   input  logic                    rst_n,
   input  logic                    tick,
   input  logic [NUM_CH-1:0]       start_stop,
   input  logic [NUM_CH-1:0]       pause_resume,
   input  logic [NUM_CH-1:0]       clear,
   input  logic [NUM_CH-1:0]       lap,
   output logic [NUM_CH-1:0]       running,
   output logic [NUM_CH-1:0]       paused,
   output logic [NUM_CH-1:0]       wrap,
   output logic [NUM_CH*CNT_W-1:0] count,
   output logic [NUM_CH*CNT_W-1:0] disp_count
);

   // One channel per slice, buses packed channel-major
   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      stopwatch_channel #(
         .MAX_COUNT (MAX_COUNT),
         .CNT_W     (CNT_W)
      ) u_ch (
         .clk_100      (clk_100),
         .rst_n        (rst_n),
         .tick         (tick),
         .start_stop   (start_stop[i]),
         .pause_resume (pause_resume[i]),
         .clear        (clear[i]),
         .lap          (lap[i]),
         .running      (running[i]),
         .paused       (paused[i]),
         .wrap         (wrap[i]),
         .count        (count[i*CNT_W +: CNT_W]),
         .disp_count   (disp_count[i*CNT_W +: CNT_W])
      );
   end

endmodule

// File: tb/tb_stopwatch_ctrl_multi.sv
// Self-checking bench for stopwatch_ctrl_multi (NUM_CH=2, MAX_COUNT=6000).
// Expected values queued with stimulus, popped after the DUT edge.
module tb_stopwatch_ctrl_multi;

   localparam int NUM_CH = 2;
   localparam int MAXC   = 6000;
   localparam int CNT_W  = $clog2(MAXC);

   logic                    clk_100;
   logic                    rst_n;
   logic                    tick;
   logic [NUM_CH-1:0]       start_stop;
   logic [NUM_CH-1:0]       pause_resume;
   logic [NUM_CH-1:0]       clear;
   logic [NUM_CH-1:0]       lap;
   logic [NUM_CH-1:0]       running;
   logic [NUM_CH-1:0]       paused;
   logic [NUM_CH-1:0]       wrap;
   logic [NUM_CH*CNT_W-1:0] count;
   logic [NUM_CH*CNT_W-1:0] disp_count;

   int errors = 0;
   int checks = 0;
   int exp_q[$];
   int e;

   logic [CNT_W-1:0] c0, c1, d0;
   assign c0 = count[0 +: CNT_W];
   assign c1 = count[CNT_W +: CNT_W];
   assign d0 = disp_count[0 +: CNT_W];

   stopwatch_ctrl_multi #(
      .NUM_CH    (NUM_CH),
      .MAX_COUNT (MAXC)
   ) dut (
      .clk_100      (clk_100),
      .rst_n        (rst_n),
      .tick         (tick),
      .start_stop   (start_stop),
      .pause_resume (pause_resume),
      .clear        (clear),
      .lap          (lap),
      .running      (running),
      .paused       (paused),
      .wrap         (wrap),
      .count        (count),
      .disp_count   (disp_count)
   );

   initial clk_100 = 1'b0;
   always #5 clk_100 = ~clk_100;

   // One cycle of stimulus; outputs are stable #1 after the edge
   task automatic cyc(input logic [1:0] ss, input logic [1:0] pr,
                      input logic [1:0] cl, input logic [1:0] lp,
                      input logic tk);
      start_stop   = ss;
      pause_resume = pr;
      clear        = cl;
      lap          = lp;
      tick         = tk;
      @(posedge clk_100);
      #1;
      start_stop   = '0;
      pause_resume = '0;
      clear        = '0;
      lap          = '0;
      tick         = 1'b0;
   endtask

   task automatic ticks(input int n);
      repeat (n) cyc(2'b00, 2'b00, 2'b00, 2'b00, 1'b1);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      exp_q.push_back(0);
      exp_q.push_back(0);
      exp_q.push_back(0);
      exp_q.push_back(0);
      exp_q.push_back(0);
      exp_q.push_back(0);
      cyc(2'b11, 2'b00, 2'b00, 2'b11, 1'b1);
      cyc(2'b00, 2'b00, 2'b00, 2'b00, 1'b1);
      e = exp_q.pop_front(); checks++;
      if (int'(running) !== e) begin errors++;
         $display("FAIL reset_running got=%0d exp=%0d", running, e); end
      e = exp_q.pop_front(); checks++;
      if (int'(paused) !== e) begin errors++;
         $display("FAIL reset_paused got=%0d exp=%0d", paused, e); end
      e = exp_q.pop_front(); checks++;
      if (int'(wrap) !== e) begin errors++;
         $display("FAIL reset_wrap got=%0d exp=%0d", wrap, e); end
      e = exp_q.pop_front(); checks++;
      if (int'(c0) !== e) begin errors++;
         $display("FAIL reset_count0 got=%0d exp=%0d", c0, e); end
      e = exp_q.pop_front(); checks++;
      if (int'(c1) !== e) begin errors++;
         $display("FAIL reset_count1 got=%0d exp=%0d", c1, e); end
      e = exp_q.pop_front(); checks++;
      if (int'(d0) !== e) begin errors++;
         $display("FAIL reset_disp0 got=%0d exp=%0d", d0, e); end
      rst_n = 1'b1;
   endtask

   task automatic test_start();
      // tick coincident with start is not counted
      exp_q.push_back(1);
      exp_q.push_back(0);
      cyc(2'b01, 2'b00, 2'b00, 2'b00, 1'b1);
      e = exp_q.pop_front(); checks++;
      if (int'(running) !== e) begin errors++;
         $display("FAIL start_running got=%0d exp=%0d", running, e); end
      e = exp_q.pop_front(); checks++;
      if (int'(c0) !== e) begin errors++;
         $display("FAIL start_tick_ignored got=%0d exp=%0d", c0, e); end
      exp_q.push_back(10);
      exp_q.push_back(0);
      exp_q.push_back(1);
      ticks(10);
      e = exp_q.pop_front(); checks++;
      if (int'(c0) !== e) begin errors++;
         $display("FAIL start_count0 got=%0d exp=%0d", c0, e); end
      e = exp_q.pop_front(); checks++;
      if (int'(c1) !== e) begin errors++;
         $display("FAIL start_count1 got=%0d exp=%0d", c1, e); end
      e = exp_q.pop_front(); checks++;
      if (int'(running) !== e) begin errors++;
         $display("FAIL start_running10 got=%0d exp=%0d", running, e); end
   endtask

   task automatic test_pause();
      cyc(2'b00, 2'b00, 2'b01, 2'b00, 1'b0);
      cyc(2'b01, 2'b00, 2'b00, 2'b00, 1'b0);
      ticks(5);
      cyc(2'b00, 2'b01, 2'b00, 2'b00, 1'b0);
      exp_q.push_back(1);
      exp_q.push_back(0);
      exp_q.push_back(5);
      ticks(3);
      e = exp_q.pop_front(); checks++;
      if (int'(paused) !== e) begin errors++;
         $display("FAIL pause_paused got=%0d exp=%0d", paused, e); end
      e = exp_q.pop_front(); checks++;
      if (int'(running) !== e) begin errors++;
         $display("FAIL pause_running got=%0d exp=%0d", running, e); end
      e = exp_q.pop_front(); checks++;
      if (int'(c0) !== e) begin errors++;
         $display("FAIL pause_hold_count got=%0d exp=%0d", c0, e); end
      cyc(2'b00, 2'b01, 2'b00, 2'b00, 1'b0);
      exp_q.push_back(7);
      exp_q.push_back(0);
      ticks(2);
      e = exp_q.pop_front(); checks++;
      if (int'(c0) !== e) begin errors++;
         $display("FAIL resume_count got=%0d exp=%0d", c0, e); end
      e = exp_q.pop_front(); checks++;
      if (int'(paused) !== e) begin errors++;
         $display("FAIL resume_paused got=%0d exp=%0d", paused, e); end
   endtask

   task automatic test_priority();
      // start_stop beats pause_resume; coincident tick still counts
      exp_q.push_back(0);
      exp_q.push_back(0);
      exp_q.push_back(8);
      cyc(2'b01, 2'b01, 2'b00, 2'b00, 1'b1);
      e = exp_q.pop_front(); checks++;
      if (int'(running) !== e) begin errors++;
         $display("FAIL prio_running got=%0d exp=%0d", running, e); end
      e = exp_q.pop_front(); checks++;
      if (int'(paused) !== e) begin errors++;
         $display("FAIL prio_paused got=%0d exp=%0d", paused, e); end
      e = exp_q.pop_front(); checks++;
      if (int'(c0) !== e) begin errors++;
         $display("FAIL stop_tick_counted got=%0d exp=%0d", c0, e); end
      // pause_resume ignored in STOP
      exp_q.push_back(0);
      cyc(2'b00, 2'b01, 2'b00, 2'b00, 1'b0);
      e = exp_q.pop_front(); checks++;
      if (int'(paused) !== e) begin errors++;
         $display("FAIL stop_pr_ignored got=%0d exp=%0d", paused, e); end
      cyc(2'b00, 2'b00, 2'b01, 2'b00, 1'b0);
      cyc(2'b01, 2'b00, 2'b00, 2'b00, 1'b0);
      ticks(42);
      exp_q.push_back(42);
      e = exp_q.pop_front(); checks++;
      if (int'(c0) !== e) begin errors++;
         $display("FAIL pre_clear_count got=%0d exp=%0d", c0, e); end
      exp_q.push_back(0);
      exp_q.push_back(0);
      exp_q.push_back(0);
      cyc(2'b00, 2'b00, 2'b01, 2'b00, 1'b1);
      e = exp_q.pop_front(); checks++;
      if (int'(c0) !== e) begin errors++;
         $display("FAIL clear_count got=%0d exp=%0d", c0, e); end
      e = exp_q.pop_front(); checks++;
      if (int'(running) !== e) begin errors++;
         $display("FAIL clear_running got=%0d exp=%0d", running, e); end
      e = exp_q.pop_front(); checks++;
      if (int'(wrap) !== e) begin errors++;
         $display("FAIL clear_wrap got=%0d exp=%0d", wrap, e); end
   endtask

   task automatic test_wrap();
      cyc(2'b00, 2'b00, 2'b01, 2'b00, 1'b0);
      cyc(2'b01, 2'b00, 2'b00, 2'b00, 1'b0);
      exp_q.push_back(MAXC - 1);
      exp_q.push_back(0);
      ticks(MAXC - 1);
      e = exp_q.pop_front(); checks++;
      if (int'(c0) !== e) begin errors++;
         $display("FAIL wrap_last got=%0d exp=%0d", c0, e); end
      e = exp_q.pop_front(); checks++;
      if (int'(wrap) !== e) begin errors++;
         $display("FAIL wrap_early got=%0d exp=%0d", wrap, e); end
      exp_q.push_back(0);
      exp_q.push_back(1);
      ticks(1);
      e = exp_q.pop_front(); checks++;
      if (int'(c0) !== e) begin errors++;
         $display("FAIL wrap_zero got=%0d exp=%0d", c0, e); end
      e = exp_q.pop_front(); checks++;
      if (int'(wrap) !== e) begin errors++;
         $display("FAIL wrap_pulse got=%0d exp=%0d", wrap, e); end
      exp_q.push_back(0);
      exp_q.push_back(1);
      ticks(1);
      e = exp_q.pop_front(); checks++;
      if (int'(wrap) !== e) begin errors++;
         $display("FAIL wrap_one_cycle got=%0d exp=%0d", wrap, e); end
      e = exp_q.pop_front(); checks++;
      if (int'(c0) !== e) begin errors++;
         $display("FAIL wrap_after got=%0d exp=%0d", c0, e); end
   endtask

   task automatic test_lap();
      cyc(2'b00, 2'b00, 2'b01, 2'b00, 1'b0);
      cyc(2'b01, 2'b00, 2'b00, 2'b00, 1'b0);
      ticks(100);
      cyc(2'b00, 2'b00, 2'b00, 2'b01, 1'b0);
`ifdef STOPWATCH_LAP_EN
      exp_q.push_back(100);
`else
      exp_q.push_back(150);
`endif
      exp_q.push_back(150);
      ticks(50);
      e = exp_q.pop_front(); checks++;
      if (int'(d0) !== e) begin errors++;
         $display("FAIL lap_disp_held got=%0d exp=%0d", d0, e); end
      e = exp_q.pop_front(); checks++;
      if (int'(c0) !== e) begin errors++;
         $display("FAIL lap_count_live got=%0d exp=%0d", c0, e); end
      exp_q.push_back(150);
      cyc(2'b00, 2'b00, 2'b00, 2'b01, 1'b0);
      e = exp_q.pop_front(); checks++;
      if (int'(d0) !== e) begin errors++;
         $display("FAIL lap_release got=%0d exp=%0d", d0, e); end
      // lap outside RUN with no hold is ignored
      cyc(2'b01, 2'b00, 2'b00, 2'b00, 1'b0);
      cyc(2'b00, 2'b00, 2'b00, 2'b01, 1'b0);
      cyc(2'b01, 2'b00, 2'b00, 2'b00, 1'b0);
      exp_q.push_back(153);
      ticks(3);
      e = exp_q.pop_front(); checks++;
      if (int'(d0) !== e) begin errors++;
         $display("FAIL lap_stop_ignored got=%0d exp=%0d", d0, e); end
   endtask

   task automatic test_mid_reset();
      cyc(2'b00, 2'b00, 2'b11, 2'b00, 1'b0);
      cyc(2'b11, 2'b00, 2'b00, 2'b00, 1'b0);
      ticks(300);
      exp_q.push_back(300);
      e = exp_q.pop_front(); checks++;
      if (int'(c1) !== e) begin errors++;
         $display("FAIL pre_reset_count1 got=%0d exp=%0d", c1, e); end
      rst_n = 1'b0;
      exp_q.push_back(0);
      exp_q.push_back(0);
      exp_q.push_back(0);
      exp_q.push_back(0);
      cyc(2'b11, 2'b11, 2'b00, 2'b11, 1'b1);
      rst_n = 1'b1;
      e = exp_q.pop_front(); checks++;
      if (int'(running) !== e) begin errors++;
         $display("FAIL mreset_running got=%0d exp=%0d", running, e); end
      e = exp_q.pop_front(); checks++;
      if (int'(c0) !== e) begin errors++;
         $display("FAIL mreset_count0 got=%0d exp=%0d", c0, e); end
      e = exp_q.pop_front(); checks++;
      if (int'(c1) !== e) begin errors++;
         $display("FAIL mreset_count1 got=%0d exp=%0d", c1, e); end
      e = exp_q.pop_front(); checks++;
      if (int'(paused | wrap) !== e) begin errors++;
         $display("FAIL mreset_flags got=%0d exp=%0d", paused | wrap, e); end
      // still STOP after reset: ticks do nothing
      exp_q.push_back(0);
      ticks(2);
      e = exp_q.pop_front(); checks++;
      if (int'(c0) !== e) begin errors++;
         $display("FAIL mreset_stopped got=%0d exp=%0d", c0, e); end
   endtask

   initial begin
      rst_n        = 1'b0;
      tick         = 1'b0;
      start_stop   = '0;
      pause_resume = '0;
      clear        = '0;
      lap          = '0;
      test_reset();
      test_start();
      test_pause();
      test_priority();
      test_wrap();
      test_lap();
      test_mid_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
